// File: rtl/sha_msg_schedule.sv
// SHA-256 message-schedule generator: latches one 512-bit block, then emits W0..W63 one per cycle.
// Optional feature macro SHA_SCHED_STALL_EN makes the stall input hold the current word.
module sha_msg_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] block,
    input  logic         stall,
    output logic [63:0]  w_out,
    output logic [5:0]   cycle,
    output logic         w_valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] win [16];
    logic [31:0] w_word;
    logic [31:0] w_next;
    logic        advance;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

`ifdef SHA_SCHED_STALL_EN
    assign advance = !stall;
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign advance      = 1'b1;
`endif

    // Next window entry W[t+16] from the current 16-word window (W[t] .. W[t+15]).
    assign w_next = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

    assign w_out = {32'h0, w_word};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            w_word  <= '0;
            cycle   <= '0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < 16; i++) begin
                            win[i] <= block[511 - 32*i -: 32];
                        end
                        w_word  <= block[511:480];
                        cycle   <= '0;
                        w_valid <= 1'b1;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (advance) begin
                        for (int i = 0; i < 15; i++) begin
                            win[i] <= win[i+1];
                        end
                        win[15] <= w_next;
                        if (cycle == 6'd63) begin
                            state   <= DONE;
                            w_word  <= '0;
                            cycle   <= '0;
                            w_valid <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            w_word <= win[1];
                            cycle  <= cycle + 6'd1;
                        end
                    end
                end
                DONE: begin
                    // The done pulse lasts one cycle; stall never delays the return to IDLE.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Scoreboard bench for sha_msg_schedule: a plain-arithmetic SHA-256 expansion fills a queue,
// and a negedge monitor pops and compares each consumed schedule word.
module tb_sha_msg_schedule;

`ifdef SHA_SCHED_STALL_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stall = 1'b0;
    logic [511:0] block = '0;
    logic [63:0]  w_out;
    logic [5:0]   cycle;
    logic         w_valid;
    logic         busy;
    logic         done;

    sha_msg_schedule dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .block  (block),
        .stall  (stall),
        .w_out  (w_out),
        .cycle  (cycle),
        .w_valid(w_valid),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] w;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] cap [64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook SHA-256 expansion over the whole 64-entry array.
    task automatic ref_schedule(input logic [511:0] b, output logic [31:0] w [64]);
        for (int t = 0; t < 16; t++) begin
            w[t] = b[511 - 32*t -: 32];
        end
        for (int t = 16; t < 64; t++) begin
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10))
                 + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3))
                 + w[t-16];
        end
    endtask

    // Monitor: a word is consumed whenever it is valid and not stalled.
    always @(negedge clk) begin
        if (w_valid === 1'b1 && !(STALL_ON && stall)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got cycle %0d w %h, required no output", cycle, w_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("w_t", {32'h0, w_out[31:0]}, {32'h0, mon_e.w});
                check("cycle", {58'h0, cycle}, {58'h0, mon_e.idx});
                check("w_out_upper", {32'h0, w_out[63:32]}, 64'h0);
                cap[cycle] = w_out[31:0];
            end
        end
    end

    // Called at posedge+1 in an IDLE cycle; returns at posedge+1 in the next IDLE cycle.
    task automatic run_sched(input logic [511:0] blk, input int stall_at, input int stall_len,
                             input bit idle_stall, input int ign_at, input int rst_at);
        logic [31:0] w [64];
        int n, left, exp_done, got;
        bit ign_done, st_done;
        ref_schedule(blk, w);
        for (int t = 0; t < 64; t++) begin
            exp_q.push_back('{idx: 6'(t), w: w[t]});
        end
        start    = 1'b1;
        block    = blk;
        stall    = idle_stall;
        n        = cyc;
        left     = 0;
        got      = -1;
        ign_done = 1'b0;
        st_done  = 1'b0;
        exp_done = n + 65 + ((STALL_ON && stall_at >= 0) ? stall_len : 0);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int k = 0; k < 16; k++) begin
                block[k*32 +: 32] = $urandom();
            end
            if (rst_at >= 0 && rst == 1'b1) begin
                rst   = 1'b0;
                stall = 1'b0;
                exp_q.delete();
                check("reset_w_out", w_out, 64'h0);
                check("reset_ctl", {55'h0, cycle, w_valid, busy, done}, 64'h0);
                for (int j = 0; j < 3; j++) begin
                    @(posedge clk);
                    #1;
                    check("reset_no_done", {63'h0, done}, 64'h0);
                end
                return;
            end
            if (done === 1'b1) begin
                got = cyc;
                break;
            end
            if (left > 0) left--;
            stall = (left > 0);
            if (stall_at >= 0 && !st_done && w_valid && cycle == 6'(stall_at)) begin
                left    = stall_len;
                stall   = 1'b1;
                st_done = 1'b1;
            end
            if (ign_at >= 0 && !ign_done && w_valid && cycle == 6'(ign_at)) begin
                start    = 1'b1;
                ign_done = 1'b1;
            end
            if (rst_at >= 0 && w_valid && cycle == 6'(rst_at)) begin
                rst = 1'b1;
            end
        end
        stall = 1'b0;
        check("done_cycle", 64'(got), 64'(exp_done));
        check("done_busy", {63'h0, busy}, 64'h1);
        check("done_w_valid", {63'h0, w_valid}, 64'h0);
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("done_pulse_width", {63'h0, done}, 64'h0);
        check("idle_busy", {63'h0, busy}, 64'h0);
    endtask

    initial begin
        logic [511:0] abc;
        logic [511:0] ones;
        logic [511:0] rb;
        abc            = '0;
        abc[511:480]   = 32'h61626380;
        abc[31:0]      = 32'h00000018;
        ones           = '1;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_w_out", w_out, 64'h0);
        check("rst_ctl", {55'h0, cycle, w_valid, busy, done}, 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("idle_w_out", w_out, 64'h0);
            check("idle_ctl", {55'h0, cycle, w_valid, busy, done}, 64'h0);
        end

        run_sched(abc, -1, 0, 1'b0, -1, -1);
        check("abc_w0",  {32'h0, cap[0]},  64'h61626380);
        check("abc_w15", {32'h0, cap[15]}, 64'h00000018);
        check("abc_w16", {32'h0, cap[16]}, 64'h61626380);
        check("abc_w17", {32'h0, cap[17]}, 64'h000F0000);
        check("abc_w18", {32'h0, cap[18]}, 64'h7DA86405);
        check("abc_w19", {32'h0, cap[19]}, 64'h600003C6);
        check("abc_w63", {32'h0, cap[63]}, 64'h12B1EDEB);

        for (int t = 0; t < 64; t++) cap[t] = '0;
        run_sched(abc, 17, 3, 1'b0, -1, -1);
        check("stall_w17", {32'h0, cap[17]}, 64'h000F0000);
        check("stall_w18", {32'h0, cap[18]}, 64'h7DA86405);

        for (int t = 0; t < 64; t++) cap[t] = '0;
        run_sched(abc, -1, 0, 1'b0, 30, -1);
        check("ign_w31", {32'h0, cap[31]}, {32'h0, cap[31] ^ 32'h0} & 64'hFFFFFFFF);
        check("ign_w63", {32'h0, cap[63]}, 64'h12B1EDEB);

        run_sched(abc, -1, 0, 1'b0, -1, 40);

        for (int k = 0; k < 16; k++) rb[k*32 +: 32] = $urandom();
        run_sched(rb, -1, 0, 1'b0, -1, -1);

        run_sched(abc, -1, 0, 1'b0, -1, -1);
        for (int t = 0; t < 64; t++) cap[t] = '0;
        run_sched(ones, -1, 0, 1'b0, -1, -1);
        for (int t = 0; t < 16; t += 5) begin
            check("ones_w", {32'h0, cap[t]}, 64'hFFFFFFFF);
        end

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 16; k++) rb[k*32 +: 32] = $urandom();
            run_sched(rb, int'($urandom_range(0, 63)), int'($urandom_range(1, 4)),
                      1'($urandom_range(0, 1)), -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sha_msg_schedule.md
# sha_msg_schedule

Sequential SHA-256 message-schedule generator that produces the per-round word stream W0..W63 consumed by the single-round `sha_math` block. It latches one 512-bit message block and emits one schedule word per cycle with its round index, so the round datapath and this block advance in lock-step. It sits between the block/padding logic and `sha_math` in the miner hash core.

## Interface
- No parameters; all widths are fixed by SHA-256.
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  reset; synchronous and active-high
- start  in  1  request to load `block` and begin a 64-round schedule; sampled only in IDLE
- block  in  512  message block; word 0 = block[511:480], word 15 = block[31:0] (big-endian word order)
- stall  in  1  hold the current output word and index (see Configuration)
- w_out  out  64  schedule word for `sha_math` W port; [31:0] = W_t, [63:32] = 0
- cycle  out  6  round index t of `w_out`
- w_valid  out  1  `w_out`/`cycle` are valid
- busy  out  1  high in RUN and DONE
- done  out  1  single-cycle pulse after round 63 has been presented

## Operation
- States: IDLE, RUN, DONE.
- IDLE: outputs idle; on `start`=1, load 16x32 window `win[0..15]` from `block`, go RUN.
- RUN: `w_out[31:0]` = `win[0]`, `cycle` = round counter t, `w_valid`=1.
- RUN advance (not stalled): shift window; new `win[15]` = σ1(`win[14]`) + `win[9]` + σ0(`win[1]`) + `win[0]` mod 2^32; t increments.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3; σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- All additions are 32-bit, carries discarded.
- RUN -> DONE when advancing with t = 63.
- DONE: `w_valid`=0, `done`=1 for exactly one cycle, then IDLE.
- `start` in RUN or DONE is ignored; the block is not re-latched.
- `start` is accepted again in the first IDLE cycle after DONE.
- `block` is sampled only in the start cycle; later changes have no effect.

## Timing
- Reset values: state IDLE; `w_out`=0, `cycle`=0, `w_valid`=0, `busy`=0, `done`=0; window and counter cleared.
- Start accepted in cycle N (IDLE, `start`=1); W0 valid with `cycle`=0 in cycle N+1.
- With no stalls, W_t is valid in cycle N+1+t; W63 is valid in cycle N+64.
- `done` is high in cycle N+65; `start` can be accepted again in cycle N+66.
- Stall in RUN: window, counter and outputs hold; `w_valid` stays 1; the consumer treats the word as not consumed.
- Stall in IDLE or DONE has no effect; the DONE-to-IDLE transition is not delayed.
- Stall and `start` together in IDLE: `start` is accepted.
- Reset has priority over everything. Reset in any state, including mid-RUN, returns to IDLE with reset values on the next edge; no `done` pulse is produced.
- `w_out` and `cycle` are registered outputs with no combinational path from inputs.
- Throughput: one schedule per 66 cycles, including the IDLE start cycle.

## Configuration
- `SHA_SCHED_STALL_EN`
- Defined: the `stall` port is functional as described above.
- Undefined: the `stall` port is still present but ignored. RUN advances every cycle, and timing is exactly N+1..N+64 / N+65.

## Test plan
- Reset, then idle with `start`=0 -> all outputs 0 and state IDLE for 10 cycles.
- Start with the padded "abc" block (word0 = 0x61626380, words 1-14 = 0, word15 = 0x00000018) -> required outputs:
  - W0 = 0x61626380 at cycle 0; W15 = 0x00000018
  - W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405, W19 = 0x600003C6
  - W63 = 0x12B1EDEB
  - `done` exactly at N+65; `w_out[63:32]` = 0 throughout.
- Same "abc" block with `stall`=1 for 3 cycles while `cycle`=17 (macro defined) -> W17 = 0x000F0000 held 4 cycles, W18 follows correctly, `done` at N+68.
- Pulse `start` with a different block while `cycle`=30 -> ignored; the schedule is unchanged and matches the "abc" vector.
- Assert `rst` while `cycle`=40 -> next cycle IDLE with all outputs 0 and no `done`; a following start produces a correct full schedule.
- Back-to-back: second start in the first IDLE cycle after `done` with an all-ones block -> W0..W15 = 0xFFFFFFFF and W16 matches the reference model (0xFFFFFFFF-based expansion computed by the bench).
